rom_fetch_ctrl: RTL

Fetch controller that sits directly upstream of the instruction ROM (`blk_mem_0`) on the board-level memory demo. It turns a debounced step button, or a free-running auto-step tick, into single ROM read requests. It drives `ena`/`addra` and captures the 32-bit word the ROM returns one cycle later into a held instruction register for the seven-segment display path. It also lets the user load an arbitrary start address from switches.

---
 rtl/rom_fetch_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rom_fetch_ctrl.sv
// ROM fetch controller: conditions step/load buttons and an auto-step tick into
// single-cycle ROM read requests, and holds the returned word for display.
module rom_fetch_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int DB_COUNT = 1_000_000,
  parameter int AUTO_DIV = 50_000_000
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              btn_step,
  input  logic              btn_load,
  input  logic              mode_auto,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [DATA_W-1:0] douta,
  output logic              ena,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              busy
);

  localparam int DB_W   = $clog2(DB_COUNT);
  localparam int AUTO_W = $clog2(AUTO_DIV);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  // Bit 0 carries the step button, bit 1 the load button.
  logic [1:0]        w_raw;
  logic [1:0]        r_sync1;
  logic [1:0]        r_sync2;
  logic [1:0]        r_db;
  logic [1:0]        r_db_q;
  logic [DB_W-1:0]   r_db_cnt [2];
  logic [1:0]        w_ev;
  logic              w_step_ev;
  logic              w_load_ev;

  logic              r_mode_s1;
  logic              r_mode_s2;
  logic [AUTO_W-1:0] r_div_cnt;
  logic              w_tick;
  logic              w_fetch_ev;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_inst;
  logic              r_inst_valid;

  assign w_raw = {btn_load, btn_step};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_q  <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_W'(DB_COUNT - 1)) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_ev      = r_db & ~r_db_q;
  assign w_step_ev = w_ev[0];
  assign w_load_ev = w_ev[1];

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_mode_s1 <= 1'b0;
      r_mode_s2 <= 1'b0;
      r_div_cnt <= '0;
    end else begin
      r_mode_s1 <= mode_auto;
      r_mode_s2 <= r_mode_s1;
      if (!r_mode_s2 || r_div_cnt == AUTO_W'(AUTO_DIV - 1)) r_div_cnt <= '0;
      else                                                  r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign w_tick     = r_mode_s2 && (r_div_cnt == AUTO_W'(AUTO_DIV - 1));
  assign w_fetch_ev = w_step_ev | w_tick;

  // NOTE: the next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (!w_load_ev && w_fetch_ev) w_next_state = S_REQ;
      S_REQ:   w_next_state = S_WAIT;
      S_WAIT:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Events seen outside IDLE are simply ignored: nothing here queues them.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_inst_valid <= 1'b0;
      if (r_state == S_IDLE && w_load_ev) r_pc <= start_addr;
      if (r_state == S_WAIT) begin
        r_inst       <= douta;
        r_inst_valid <= 1'b1;
        r_pc         <= r_pc + 1'b1;
      end
    end
  end

  assign ena        = (r_state == S_REQ);
  assign busy       = (r_state != S_IDLE);
  assign addra      = r_pc;
  assign inst       = r_inst;
  assign inst_valid = r_inst_valid;

endmodule
